// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer (IDLE -> GAP -> UP -> ... -> DONE).
// Define MOLE_SPEEDUP_EN to shorten the up-time by one tick per hit (floor 2).
module mole_scheduler #(
    parameter int UP_TICKS = 16,
    parameter int GAP_MIN  = 4,
    parameter int ROUNDS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       tick,
    input  logic [7:0] rnd,
    input  logic [7:0] whack,
    output logic [7:0] mole,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

    state_t     state_q;
    logic [7:0] gap_q, up_q, round_q, score_q, mole_q;
    logic [2:0] prev_q;
    logic       hit_q, miss_q;
    logic [7:0] gap_d, round_d, score_d, mole_d, up_time;
    logic [2:0] idx_d;
    logic       hit_d, last_d;
    logic       unused_rnd;

`ifdef MOLE_SPEEDUP_EN
    logic [7:0] uptime_q;
    assign up_time = uptime_q;
`else
    assign up_time = 8'(UP_TICKS);
`endif

    assign unused_rnd = rnd[4];

    always_comb begin
        gap_d   = 8'(GAP_MIN) + {4'd0, rnd[3:0]};
        idx_d   = (rnd[7:5] == prev_q) ? rnd[7:5] + 3'd1 : rnd[7:5];
        mole_d  = 8'd1 << idx_d;
        hit_d   = |(whack & mole_q);
        round_d = round_q + 8'd1;
        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        last_d  = round_d == 8'(ROUNDS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gap_q    <= 8'd0;
            up_q     <= 8'd0;
            round_q  <= 8'd0;
            score_q  <= 8'd0;
            mole_q   <= 8'd0;
            prev_q   <= 3'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
            uptime_q <= 8'(UP_TICKS);
`endif
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q  <= GAP;
                    score_q  <= 8'd0;
                    round_q  <= 8'd0;
                    gap_q    <= gap_d;
`ifdef MOLE_SPEEDUP_EN
                    uptime_q <= 8'(UP_TICKS);
`endif
                end
                GAP: if (tick) begin
                    if (gap_q == 8'd1) begin
                        state_q <= UP;
                        up_q    <= up_time;
                        mole_q  <= mole_d;
                        prev_q  <= idx_d;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                UP: if (hit_d || (tick && up_q == 8'd1)) begin
                    // a whack landing on the final tick still counts as a hit
                    hit_q   <= hit_d;
                    miss_q  <= !hit_d;
                    round_q <= round_d;
                    mole_q  <= 8'd0;
                    if (hit_d) begin
                        score_q  <= score_d;
`ifdef MOLE_SPEEDUP_EN
                        uptime_q <= (uptime_q > 8'd2) ? uptime_q - 8'd1 : 8'd2;
`endif
                    end
                    if (last_d) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= GAP;
                        gap_q   <= gap_d;
                    end
                end else if (tick) begin
                    up_q <= up_q - 8'd1;
                end
            endcase
        end
    end

    assign mole  = mole_q;
    assign hit   = hit_q;
    assign miss  = miss_q;
    assign score = score_q;
    assign busy  = (state_q == GAP) || (state_q == UP);
    assign done  = state_q == DONE;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: vector table plus hand-written game sequences, scoreboard-checked.
module tb_mole_scheduler;
    localparam int ROUNDS = 3;
`ifdef MOLE_SPEEDUP_EN
    localparam int UPT2 = 14;
`else
    localparam int UPT2 = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, tick;
    logic [7:0] rnd, whack, mole, score;
    logic       hit, miss, busy, done;

    mole_scheduler #(.UP_TICKS(16), .GAP_MIN(4), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .rnd(rnd), .whack(whack),
        .mole(mole), .hit(hit), .miss(miss), .score(score), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rn, s, t;
        logic [7:0] r, w;
        logic [7:0] e_mole;
        logic       e_hit, e_miss;
        logic [7:0] e_score;
        logic       e_busy, e_done;
    } vec_t;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic step(input string nm, input logic rn, s, t, input logic [7:0] r, w,
                        input logic [7:0] e_mole, input logic e_hit, e_miss,
                        input logic [7:0] e_score, input logic e_busy, e_done);
        exp_t e;
        logic [19:0] got;
        rst_n = rn; start = s; tick = t; rnd = r; whack = w;
        sb.push_back('{nm, {e_mole, e_hit, e_miss, e_score, e_busy, e_done}});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got = {mole, hit, miss, score, busy, done};
        n_chk++;
        if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got mole=%h hit=%b miss=%b score=%0d busy=%b done=%b, want mole=%h hit=%b miss=%b score=%0d busy=%b done=%b",
                     e.nm, got[19:12], got[11], got[10], got[9:2], got[1], got[0],
                     e.v[19:12], e.v[11], e.v[10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    // n ticks of gap; the last one raises the mole
    task automatic to_mole(input string nm, input int n, input logic [7:0] r, input logic [7:0] m,
                           input logic [7:0] sc);
        for (int i = 0; i < n - 1; i++) step({nm, "_gap"}, 1, 0, 1, r, 8'h00, 8'h00, 0, 0, sc, 1, 0);
        step({nm, "_up"}, 1, 0, 1, r, 8'h00, m, 0, 0, sc, 1, 0);
    endtask

    task automatic whack_it(input string nm, input logic [7:0] m, input logic [7:0] sc, input logic last);
        step(nm, 1, 0, 0, 8'h20, m, 8'h00, 1, 0, sc, !last, last);
    endtask

    task automatic time_out(input string nm, input int n, input logic [7:0] m, input logic [7:0] sc,
                            input logic last);
        for (int i = 0; i < n - 1; i++) step({nm, "_hold"}, 1, 0, 1, 8'h20, 8'h00, m, 0, 0, sc, 1, 0);
        step({nm, "_miss"}, 1, 0, 1, 8'h20, 8'h00, 8'h00, 0, 1, sc, !last, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[3];
        tbl[0] = '{"rst_prio", 0, 1, 1, 8'hAB, 8'hFF, 8'h00, 0, 0, 8'd0, 0, 0};
        tbl[1] = '{"idle",     1, 0, 1, 8'hAB, 8'hFF, 8'h00, 0, 0, 8'd0, 0, 0};
        tbl[2] = '{"start",    1, 1, 0, 8'hAB, 8'h00, 8'h00, 0, 0, 8'd0, 1, 0};
        rst_n = 0; start = 0; tick = 0; rnd = 0; whack = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            step(tbl[i].nm, tbl[i].rn, tbl[i].s, tbl[i].t, tbl[i].r, tbl[i].w, tbl[i].e_mole,
                 tbl[i].e_hit, tbl[i].e_miss, tbl[i].e_score, tbl[i].e_busy, tbl[i].e_done);
        // game 1: gap of 4+11 ticks, start pulses in GAP must not reload it
        for (int i = 1; i < 15; i++)
            step("gap15", 1, (i % 3) == 0, 1, 8'hAB, 8'h00, 8'h00, 0, 0, 8'd0, 1, 0);
        step("mole20", 1, 0, 1, 8'hAB, 8'h00, 8'h20, 0, 0, 8'd0, 1, 0);
        step("unlit", 1, 1, 0, 8'hAB, 8'h01, 8'h20, 0, 0, 8'd0, 1, 0);
        step("hit1", 1, 0, 0, 8'h00, 8'h20, 8'h00, 1, 0, 8'd1, 1, 0);
        step("hit_once", 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'd1, 1, 0);
        to_mole("m80", 4, 8'hE0, 8'h80, 8'd1);
        for (int i = 0; i < 8; i++) step("up_a", 1, 0, 1, 8'hE0, 8'h00, 8'h80, 0, 0, 8'd1, 1, 0);
        step("no_tick", 1, 0, 0, 8'hE0, 8'h00, 8'h80, 0, 0, 8'd1, 1, 0);
        for (int i = 0; i < 7; i++) step("up_b", 1, 0, 1, 8'hE0, 8'h00, 8'h80, 0, 0, 8'd1, 1, 0);
        step("miss16", 1, 0, 1, 8'hE0, 8'h00, 8'h00, 0, 1, 8'd1, 1, 0);
        step("miss_once", 1, 0, 0, 8'hE0, 8'h00, 8'h00, 0, 0, 8'd1, 1, 0);
        to_mole("wrap", 4, 8'hE0, 8'h01, 8'd1);
        for (int i = 0; i < 15; i++) step("up_c", 1, 0, 1, 8'hE0, 8'h00, 8'h01, 0, 0, 8'd1, 1, 0);
        step("hit_vs_tmo", 1, 0, 1, 8'hE0, 8'h01, 8'h00, 1, 0, 8'd2, 0, 1);
        step("done_hold", 1, 0, 1, 8'hE0, 8'hFF, 8'h00, 0, 0, 8'd2, 0, 1);
        // game 2: two hits, then a timeout measures the up-time
        step("start2", 1, 1, 0, 8'h20, 8'h00, 8'h00, 0, 0, 8'd0, 1, 0);
        to_mole("g2r1", 4, 8'h20, 8'h02, 8'd0);
        whack_it("g2h1", 8'h02, 8'd1, 0);
        to_mole("g2r2", 4, 8'h20, 8'h04, 8'd1);
        whack_it("g2h2", 8'h04, 8'd2, 0);
        to_mole("g2r3", 4, 8'h20, 8'h02, 8'd2);
        time_out("g2t", UPT2, 8'h02, 8'd2, 1);
        // game 3: three hits end the game
        step("start3", 1, 1, 0, 8'h20, 8'h00, 8'h00, 0, 0, 8'd0, 1, 0);
        to_mole("g3r1", 4, 8'h20, 8'h04, 8'd0);
        whack_it("g3h1", 8'h04, 8'd1, 0);
        to_mole("g3r2", 4, 8'h20, 8'h02, 8'd1);
        whack_it("g3h2", 8'h02, 8'd2, 0);
        to_mole("g3r3", 4, 8'h20, 8'h04, 8'd2);
        whack_it("g3h3", 8'h04, 8'd3, 1);
        step("done3", 1, 0, 1, 8'h20, 8'h00, 8'h00, 0, 0, 8'd3, 0, 1);
        // game 4: reset mid-UP
        step("start4", 1, 1, 0, 8'h20, 8'h00, 8'h00, 0, 0, 8'd0, 1, 0);
        to_mole("g4r1", 4, 8'h20, 8'h02, 8'd0);
        for (int i = 0; i < 3; i++) step("g4up", 1, 0, 1, 8'h20, 8'h00, 8'h02, 0, 0, 8'd0, 1, 0);
        step("rst_mid", 0, 1, 1, 8'h20, 8'h02, 8'h00, 0, 0, 8'd0, 0, 0);
        step("post_rst", 1, 0, 1, 8'h20, 8'h02, 8'h00, 0, 0, 8'd0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
